// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises I-side and D-side block transfers onto one
// shared slow-memory port, with saturating per-client transaction counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [DATA_W-1:0] mem_wdata_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,

  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic [CNT_W-1:0]  cnt_I,
  output logic [CNT_W-1:0]  cnt_D,
  output logic [CNT_W-1:0]  cnt_conflict
);

  // state  | meaning
  // IDLE   | no transfer in flight; pending requests are arbitrated here
  // GNT_I  | shared port owned by the I-side client, waiting for mem_ready
  // GNT_D  | shared port owned by the D-side client, waiting for mem_ready
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   last_gnt_d;
  logic   req_I;
  logic   req_D;
  logic   pick_D;

  assign req_I  = mem_read_I | mem_write_I;
  assign req_D  = mem_read_D | mem_write_D;
  // On a tie the client that did not win last time gets the port.
  assign pick_D = req_D && (!req_I || !last_gnt_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_gnt_d   <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cnt_I        <= '0;
      cnt_D        <= '0;
      cnt_conflict <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_I || req_D) begin
            // A simultaneous read+write is presented as a write.
            if (pick_D) begin
              state      <= GNT_D;
              mem_read   <= mem_read_D & ~mem_write_D;
              mem_write  <= mem_write_D;
              mem_addr   <= mem_addr_D;
              mem_wdata  <= mem_wdata_D;
              last_gnt_d <= 1'b1;
            end else begin
              state      <= GNT_I;
              mem_read   <= mem_read_I & ~mem_write_I;
              mem_write  <= mem_write_I;
              mem_addr   <= mem_addr_I;
              mem_wdata  <= mem_wdata_I;
              last_gnt_d <= 1'b0;
            end
            if (req_I && req_D && cnt_conflict != CNT_MAX)
              cnt_conflict <= cnt_conflict + 1'b1;
          end
        end
        GNT_I: begin
          if (mem_ready) begin
            if (cnt_I != CNT_MAX) cnt_I <= cnt_I + 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= IDLE;
          end
        end
        GNT_D: begin
          if (mem_ready) begin
            if (cnt_D != CNT_MAX) cnt_D <= cnt_D + 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready_I = (state == GNT_I) && mem_ready;
  assign mem_ready_D = (state == GNT_D) && mem_ready;
  assign mem_rdata_I = (state == GNT_I) ? mem_rdata : '0;
  assign mem_rdata_D = (state == GNT_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both clients and the
// shared memory, with hand-computed grant order, data and counter values.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read_I, mem_write_I, mem_read_D, mem_write_D;
  logic [27:0]  mem_addr_I, mem_addr_D, mem_addr;
  logic [127:0] mem_wdata_I, mem_wdata_D, mem_rdata_I, mem_rdata_D;
  logic         mem_ready_I, mem_ready_D;
  logic         mem_read, mem_write, mem_ready;
  logic [127:0] mem_wdata, mem_rdata;
  logic [3:0]   cnt_I, cnt_D, cnt_conflict;

  int n_chk = 0;
  int n_bad = 0;

  // results of the last shared-port transaction served by mem_txn
  logic         t_gi, t_gd, t_gr, t_gw, t_stable;
  logic [127:0] t_rdi, t_rdd, t_gwd;
  logic [27:0]  t_ga;
  int           t_waited;

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cnt_I(cnt_I), .cnt_D(cnt_D), .cnt_conflict(cnt_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory side: wait for a shared request, answer it dly cycles into the grant.
  task automatic mem_txn(input int dly, input logic [127:0] rd);
    logic found;
    found = 1'b0;
    t_waited = 0;
    t_gi = 1'b0; t_gd = 1'b0; t_rdi = '0; t_rdd = '0;
    while (!found && t_waited < 20) begin
      @(posedge clk); #1;
      t_waited++;
      if (mem_read || mem_write) found = 1'b1;
    end
    chk("grant_seen", found, 1'b1);
    if (!found) return;
    t_ga = mem_addr; t_gr = mem_read; t_gw = mem_write; t_gwd = mem_wdata;
    t_stable = 1'b1;
    for (int c = 1; c < dly; c++) begin
      @(posedge clk); #1;
      if (mem_addr !== t_ga || mem_read !== t_gr || mem_write !== t_gw ||
          mem_wdata !== t_gwd || mem_ready_I || mem_ready_D)
        t_stable = 1'b0;
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    #1;
    t_gi = mem_ready_I; t_gd = mem_ready_D; t_rdi = mem_rdata_I; t_rdd = mem_rdata_D;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ni, nd;
    logic exp_d;
    logic [127:0] rd;

    rst = 1'b1;
    mem_read_I = 1'b1; mem_write_I = 1'b0; mem_addr_I = 28'h0000010; mem_wdata_I = '0;
    mem_read_D = 1'b1; mem_write_D = 1'b0; mem_addr_D = 28'h0000020; mem_wdata_D = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // reset held 3 cycles with both clients requesting
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", mem_read, 1'b0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_addr", mem_addr, 28'h0);
    chk("rst_wdata", mem_wdata, 128'h0);
    chk("rst_cnts", {cnt_I, cnt_D, cnt_conflict}, 12'h000);
    chk("rst_ready", {mem_ready_I, mem_ready_D}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // first tie goes to D
    mem_txn(2, 128'h1111);
    chk("first_addr", t_ga, 28'h0000020);
    chk("first_gnt", {t_gi, t_gd}, 2'b01);
    chk("first_rdata_D", t_rdd, 128'h1111);
    chk("first_conflict", cnt_conflict, 4'd1);
    mem_read_D = 1'b0;
    chk("first_read_low", mem_read, 1'b0);
    chk("first_cnt_D", cnt_D, 4'd1);

    // single I read, 4 cycles of memory latency
    mem_txn(4, {16{8'hA5}});
    chk("ird_addr", t_ga, 28'h0000010);
    chk("ird_gnt", {t_gi, t_gd}, 2'b10);
    chk("ird_rdata_I", t_rdi, {16{8'hA5}});
    chk("ird_rdata_D", t_rdd, 128'h0);
    chk("ird_stable", t_stable, 1'b1);
    chk("ird_gap", t_waited, 1);
    mem_read_I = 1'b0;
    chk("ird_read_low", mem_read, 1'b0);
    chk("ird_cnt_I", cnt_I, 4'd1);

    // alternation: 4 reads per client, issued back to back
    ni = 0; nd = 0;
    mem_read_I = 1'b1; mem_addr_I = 28'h100;
    mem_read_D = 1'b1; mem_addr_D = 28'h200;
    for (int j = 0; j < 8; j++) begin
      rd = 128'h1000 + 128'(j);
      mem_txn(1 + j % 3, rd);
      exp_d = (j % 2 == 0);
      chk("alt_gnt", {t_gi, t_gd}, exp_d ? 2'b01 : 2'b10);
      chk("alt_addr", t_ga, exp_d ? 28'h200 + 28'(nd) : 28'h100 + 28'(ni));
      chk("alt_rdata", exp_d ? t_rdd : t_rdi, rd);
      chk("alt_gap", t_waited, 1);
      chk("alt_read_low", mem_read, 1'b0);
      if (t_gd) begin
        nd++;
        if (nd < 4) mem_addr_D = 28'h200 + 28'(nd);
        else mem_read_D = 1'b0;
      end
      if (t_gi) begin
        ni++;
        if (ni < 4) mem_addr_I = 28'h100 + 28'(ni);
        else mem_read_I = 1'b0;
      end
    end
    chk("alt_cnt_I", cnt_I, 4'd5);
    chk("alt_cnt_D", cnt_D, 4'd5);
    chk("alt_conflict", cnt_conflict, 4'd8);

    // D write with read also asserted: presented as a pure write
    mem_read_D = 1'b1; mem_write_D = 1'b1;
    mem_addr_D = 28'h1234567; mem_wdata_D = {4{32'hDEADBEEF}};
    mem_txn(3, 128'h0);
    chk("dwr_gnt", {t_gi, t_gd}, 2'b01);
    chk("dwr_rw", {t_gr, t_gw}, 2'b01);
    chk("dwr_addr", t_ga, 28'h1234567);
    chk("dwr_wdata", t_gwd, {4{32'hDEADBEEF}});
    chk("dwr_stable", t_stable, 1'b1);
    mem_read_D = 1'b0; mem_write_D = 1'b0;
    chk("dwr_write_low", mem_write, 1'b0);
    chk("dwr_cnt_D", cnt_D, 4'd6);
    chk("dwr_conflict", cnt_conflict, 4'd8);

    // reset in the middle of an I read, then a stale ready from memory
    mem_read_I = 1'b1; mem_addr_I = 28'h0000055;
    @(posedge clk); #1;
    chk("mrst_grant", {mem_read, mem_addr}, {1'b1, 28'h0000055});
    @(posedge clk); #1;
    rst = 1'b1;
    mem_read_I = 1'b0;
    @(negedge clk);
    chk("mrst_no_ready", mem_ready_I, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_read_low", mem_read, 1'b0);
    chk("mrst_cnts", {cnt_I, cnt_D, cnt_conflict}, 12'h000);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = '1;
    #1;
    chk("stray_ready", {mem_ready_I, mem_ready_D}, 2'b00);
    chk("stray_rdata", mem_rdata_I | mem_rdata_D, 128'h0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = '0;
    chk("stray_cnts", {cnt_I, cnt_D, cnt_conflict}, 12'h000);
    chk("stray_read", {mem_read, mem_write}, 2'b00);

    // 20 I reads against a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      mem_addr_I = 28'h300 + 28'(k);
      mem_read_I = 1'b1;
      mem_txn(1, 128'(k));
      if (k == 14) chk("sat_at_15", cnt_I, 4'd15);
    end
    mem_read_I = 1'b0;
    chk("sat_cnt_I", cnt_I, 4'd15);
    chk("sat_cnt_D", cnt_D, 4'd0);
    chk("sat_conflict", cnt_conflict, 4'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-to-one arbiter between the CHIP's instruction-side and data-side slow-memory ports and a single shared `slow_memory` instance. Sits directly downstream of CHIP, in place of the two separate `slow_memD` / `slow_memI` connections. It serialises I-cache and D-cache block transfers onto one port, using round-robin priority. It also keeps per-client transaction counters for bandwidth reports.

## Interface
- `ADDR_W`, 28: block address width (address bits [31:4]).
- `DATA_W`, 128: block data width.
- `CNT_W`, 16: statistics counter width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read_I`, `mem_write_I`  in  1 each  I-side request.
- `mem_addr_I`  in  ADDR_W  I-side block address.
- `mem_wdata_I`  in  DATA_W  I-side write data.
- `mem_rdata_I`  out  DATA_W  I-side read data.
- `mem_ready_I`  out  1  I-side completion.
- `mem_read_D`, `mem_write_D`, `mem_addr_D`, `mem_wdata_D`, `mem_rdata_D`, `mem_ready_D`: D-side, same widths and directions as the I-side ports.
- `mem_read`, `mem_write`  out  1 each  shared-port request (registered).
- `mem_addr`  out  ADDR_W  shared-port address (registered).
- `mem_wdata`  out  DATA_W  shared-port write data (registered).
- `mem_rdata`  in  DATA_W  shared-port read data.
- `mem_ready`  in  1  shared-port completion, one-cycle pulse.
- `cnt_I`, `cnt_D`  out  CNT_W each  completed transactions per client, saturating.
- `cnt_conflict`  out  CNT_W  grants made while both clients were pending, saturating.

## Operation
- **Client protocol:**
  - A client asserts read or write and holds address and data stable until it sees its ready.
  - Read and write asserted together counts as a write.
- **FSM states:** IDLE, GNT_I, GNT_D.
- **IDLE:**
  - Only I pending → GNT_I.
  - Only D pending → GNT_D.
  - Both pending → grant the client opposite to `last_gnt`, and increment `cnt_conflict`.
  - Neither pending → stay in IDLE.
- **On grant:** register the winner's read, write, address and write data into the shared-port registers, then update `last_gnt`.
- **GNT_x:**
  - Shared-port registers hold their values.
  - `mem_ready_x = mem_ready` (combinational).
  - `mem_rdata_x = mem_rdata`.
  - When `mem_ready` = 1: increment `cnt_x`, clear the `mem_read`/`mem_write` registers, go to IDLE.
- **Non-granted client:** `mem_ready` = 0 and `mem_rdata` = 0. Its request stays pending untouched.
- **Stray `mem_ready`:** ignored in IDLE. No counter changes and no client ready.
- **Counters:** saturate at 2^CNT_W−1 and never wrap.
- **Reset values** (`rst` = 1 at an edge, including mid-transaction):
  - State = IDLE.
  - `mem_read` = `mem_write` = 0; `mem_addr` = 0; `mem_wdata` = 0.
  - `last_gnt` = I, so the first tie goes to D.
  - All counters = 0.
  - An in-flight transaction is abandoned and its client receives no ready. Clients are reset by the same `rst`.

## Timing
- **Grant latency:** a request present in IDLE at edge k has the shared port driven from cycle k+1.
- **Completion:** `mem_ready` high in cycle m gives client ready in the same cycle m. `mem_read`/`mem_write` are low from m+1, and the state is IDLE at m+1.
- **Turnaround:** there is at least one IDLE cycle between transactions, so back-to-back grants are at least 2 cycles apart after a ready. The shared port never sees two requests without a deasserted cycle between them.
- **Total added latency:** 2 cycles per transaction (grant register plus IDLE turnaround) over a direct connection.
- **Requests during GNT_x:** a request arriving while the other client is being served waits. It is evaluated in the next IDLE cycle.

## Test plan
- **Reset:** hold `rst` for 3 cycles with both clients requesting → all outputs 0, state IDLE. After release, D is granted first (`mem_addr` = `mem_addr_D`) and `cnt_conflict` = 1.
- **Single I read:** I read of addr 0x0000010, memory returns ready after 4 cycles with `mem_rdata` = 0xA5…A5 → `mem_ready_I` pulses once with that data, `mem_ready_D` stays 0, `cnt_I` = 1, `mem_read` low on the following cycle.
- **Alternation:** both clients issue 4 back-to-back reads each → grants alternate D, I, D, I, …. Final counts: `cnt_I` = 4, `cnt_D` = 4, `cnt_conflict` = 7 (or 8 including the first tie), with exactly one IDLE cycle between transactions.
- **D write:** D write of addr 0x1234567 with `mem_wdata` = 0xDEADBEEF… while I is idle → `mem_write` = 1 and `mem_wdata` is passed through unchanged until ready. `mem_read` stays 0.
- **Mid-transaction reset and stray ready:** assert `rst` during GNT_I before ready → no `mem_ready_I` pulse, `mem_read` = 0 next cycle. A subsequent `mem_ready` pulse in IDLE → no client ready and counters unchanged.
- **Saturation:** with CNT_W = 4, run 20 I reads → `cnt_I` stays at 15.
